// File: rtl/timer_irq_source.sv
// ============================================================================
// timer_irq_source : memory-mapped interval timer with W1C level interrupt
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRE_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        IRQ
);

  logic [31:0]      th;
  logic [31:0]      tl;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pcnt;
  logic             en;
  logic             ie;
  logic             pend;
  logic             ovr;

  logic             wr;
  logic             wr_th;
  logic             wr_tl;
  logic             wr_tcon;
  logic             wr_pre;
  logic             tick;
  logic             tl_max;
  logic             ovf_irq;
  logic             unused_addr_bits;

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr      = MemWr & hit;
  assign wr_th   = wr & (addr[3:2] == 2'd0);
  assign wr_tl   = wr & (addr[3:2] == 2'd1);
  assign wr_tcon = wr & (addr[3:2] == 2'd2);
  assign wr_pre  = wr & (addr[3:2] == 2'd3);

  assign tick    = en & (pcnt == pre);
  assign tl_max  = (tl == 32'hFFFF_FFFF);
  assign ovf_irq = tick & tl_max & ie;

  assign unused_addr_bits = ^addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      pre  <= '0;
      pcnt <= '0;
      en   <= 1'b0;
      ie   <= 1'b0;
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (wr_pre || !en || (pcnt == pre)) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end

      if (wr_th) begin
        th <= wdata;
      end
      if (wr_pre) begin
        pre <= wdata[PRE_W-1:0];
      end

      // A CPU write to TL takes priority over the tick on the same edge
      if (wr_tl) begin
        tl <= wdata;
      end else if (tick) begin
        tl <= tl_max ? th : tl + 32'd1;
      end

      if (wr_tcon) begin
        en <= wdata[0];
        ie <= wdata[1];
      end

      // Overflow set is OR'd after the W1C mask so a coincident clear never loses it
      pend <= (pend & ~(wr_tcon & wdata[2])) | ovf_irq;
      ovr  <= (ovr  & ~(wr_tcon & wdata[3])) | (ovf_irq & pend);
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (MemRd && hit) begin
      case (addr[3:2])
        2'd0:    rdata = th;
        2'd1:    rdata = tl;
        2'd2:    rdata = {28'b0, ovr, pend, ie, en};
        default: rdata = 32'(pre);
      endcase
    end
  end

  assign IRQ = ie & pend;

endmodule

`default_nettype wire

// File: tb/tb_timer_irq_source.sv
// ============================================================================
// tb_timer_irq_source : directed bench with a behavioural register model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_irq_source;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE;
  localparam logic [31:0] A_TL   = BASE + 32'd4;
  localparam logic [31:0] A_TCON = BASE + 32'd8;
  localparam logic [31:0] A_PRE  = BASE + 32'd12;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = A_TL;
  logic        MemRd = 1'b1;
  logic        MemWr = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        hit;
  logic [31:0] rdata;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_irq_source #(
    .BASE_ADDR(BASE),
    .PRE_W    (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .MemRd(MemRd),
    .MemWr(MemWr),
    .wdata(wdata),
    .hit  (hit),
    .rdata(rdata),
    .IRQ  (IRQ)
  );

  // Behavioural model: counter as an integer, prescaler as a cycle phase
  longint unsigned m_th  = 0;
  longint unsigned m_tl  = 0;
  int              m_pre = 0;
  int              m_phase = 0;
  bit              m_en = 0, m_ie = 0, m_if = 0, m_ovr = 0;

  always @(posedge clk or negedge reset) begin : model
    bit              mine, wr, tick, wrap, n_if, n_ovr, n_en, n_ie;
    int              off, n_phase, n_pre;
    longint unsigned n_tl, n_th;
    if (!reset) begin
      m_th = 0; m_tl = 0; m_pre = 0; m_phase = 0;
      m_en = 0; m_ie = 0; m_if = 0; m_ovr = 0;
    end else begin
      mine  = ((addr >> 4) == (BASE >> 4));
      wr    = MemWr && mine;
      off   = int'(addr[3:2]);
      tick  = m_en && (m_phase == m_pre);
      wrap  = tick && (m_tl == 64'hFFFF_FFFF);

      n_th  = (wr && off == 0) ? longint'(wdata) : m_th;
      n_pre = (wr && off == 3) ? int'(wdata[15:0]) : m_pre;
      if (wr && off == 1)  n_tl = longint'(wdata);
      else if (wrap)       n_tl = m_th;
      else if (tick)       n_tl = m_tl + 1;
      else                 n_tl = m_tl;

      if (wr && off == 3)  n_phase = 0;
      else if (!m_en)      n_phase = 0;
      else                 n_phase = (m_phase + 1) % (m_pre + 1);

      n_en  = (wr && off == 2) ? wdata[0] : m_en;
      n_ie  = (wr && off == 2) ? wdata[1] : m_ie;
      n_if  = m_if;
      n_ovr = m_ovr;
      if (wr && off == 2 && wdata[2]) n_if  = 0;
      if (wr && off == 2 && wdata[3]) n_ovr = 0;
      if (wrap && m_ie) begin
        n_if = 1;
        if (m_if) n_ovr = 1;
      end

      m_th = n_th; m_tl = n_tl; m_pre = n_pre; m_phase = n_phase;
      m_en = n_en; m_ie = n_ie; m_if = n_if; m_ovr = n_ovr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [31:0] e_rd;
    logic        e_hit;
    e_hit = ((addr >> 4) == (BASE >> 4));
    e_rd  = 32'h0;
    if (MemRd && e_hit) begin
      case (addr[3:2])
        2'd0:    e_rd = m_th[31:0];
        2'd1:    e_rd = m_tl[31:0];
        2'd2:    e_rd = {28'b0, m_ovr, m_if, m_ie, m_en};
        default: e_rd = 32'(m_pre);
      endcase
    end
    chk("model_hit",   {31'b0, hit}, {31'b0, e_hit});
    chk("model_irq",   {31'b0, IRQ}, {31'b0, m_ie & m_if});
    chk("model_rdata", rdata, e_rd);
  end

  task automatic bus(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    @(posedge clk);
    #2;
    addr  = a;
    MemRd = rd;
    MemWr = wr;
    wdata = d;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus(a, 1'b0, 1'b1, d);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    bus(a, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk(name, rdata, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'b0, IRQ}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    // Overflow reload and IRQ latency
    wr_reg(A_TH, 32'hFFFF_FFFC);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_PRE, 32'h0);
    wr_reg(A_TCON, 32'h3);
    rd_reg(A_TL); lit("t1_tl0", 32'hFFFF_FFFE);
    rd_reg(A_TL); lit("t1_tl1", 32'hFFFF_FFFF);
    chk("t1_irq_low", {31'b0, IRQ}, 32'h0);
    rd_reg(A_TL); lit("t1_reload", 32'hFFFF_FFFC);
    chk("t1_irq_high", {31'b0, IRQ}, 32'h1);

    // W1C of IF keeps EN/IE and counting
    wr_reg(A_TCON, 32'h7);
    rd_reg(A_TCON); lit("t2_tcon", 32'h3);
    chk("t2_irq_low", {31'b0, IRQ}, 32'h0);
    rd_reg(A_TL); lit("t2_tl", 32'hFFFF_FFFF);
    wr_reg(A_TCON, 32'hC);

    // Prescaler phase and restart on PRE write
    wr_reg(A_TL, 32'h0);
    wr_reg(A_PRE, 32'h3);
    wr_reg(A_TCON, 32'h1);
    for (int i = 0; i <= 8; i++) begin
      rd_reg(A_TL); lit("t3_pre_step", 32'(i / 4));
    end
    rd_reg(A_TL);
    wr_reg(A_PRE, 32'h3);
    for (int j = 0; j <= 4; j++) begin
      rd_reg(A_TL); lit("t3_restart", (j == 4) ? 32'h3 : 32'h2);
    end
    wr_reg(A_TCON, 32'hC);

    // Missed interrupt and overflow set beating W1C
    wr_reg(A_TH, 32'hFFFF_FFFE);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_PRE, 32'h0);
    wr_reg(A_TCON, 32'h3);
    for (int k = 0; k < 5; k++) rd_reg(A_TCON);
    lit("t4_ovr", 32'hF);
    wr_reg(A_TCON, 32'h7);
    rd_reg(A_TCON); lit("t4_set_wins", 32'hF);
    chk("t4_irq", {31'b0, IRQ}, 32'h1);
    wr_reg(A_TCON, 32'hC);

    // CPU write beats tick; out-of-window access
    wr_reg(A_TCON, 32'h1);
    wr_reg(A_TL, 32'h10);
    rd_reg(A_TL); lit("t5_write_wins", 32'h10);
    rd_reg(A_TL); lit("t5_next", 32'h11);
    wr_reg(BASE + 32'h14, 32'hDEAD_BEEF);
    bus(BASE + 32'h10, 1'b1, 1'b0, 32'h0);
    lit("t5_miss_rdata", 32'h0);
    chk("t5_miss_hit", {31'b0, hit}, 32'h0);
    rd_reg(A_TH); lit("t5_th_kept", 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'hC);

    // Asynchronous reset with IRQ pending
    wr_reg(A_TL, 32'hFFFF_FFFF);
    wr_reg(A_TCON, 32'h3);
    rd_reg(A_TCON); lit("t6_tcon_en", 32'h3);
    rd_reg(A_TCON); lit("t6_tcon_if", 32'h7);
    chk("t6_irq_before", {31'b0, IRQ}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("t6_irq_async", {31'b0, IRQ}, 32'h0);
    chk("t6_tcon_async", rdata, 32'h0);
    addr = A_TL;
    #1;
    chk("t6_tl_async", rdata, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    rd_reg(A_TL); lit("t6_idle0", 32'h0);
    rd_reg(A_TL); lit("t6_idle1", 32'h0);
    wr_reg(A_TCON, 32'h1);
    rd_reg(A_TL); lit("t6_resume0", 32'h0);
    rd_reg(A_TL); lit("t6_resume1", 32'h1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
